axil_uart_regs: RTL and testbench

//  AXI4-Lite slave register front-end sitting directly upstream of UART (Clk/Resetn domain, same clock).

---
 rtl/axil_uart_pkg.sv | 29 ++
 rtl/axil_uart_regs.sv | 177 +++++++++++++++++
 tb/tb_axil_uart_regs.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_uart_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite UART register block.
// Register offsets are word indices (addr[3:2]).
package axil_uart_pkg;

  localparam logic [1:0] RX_OFS   = 2'd0;
  localparam logic [1:0] TX_OFS   = 2'd1;
  localparam logic [1:0] STAT_OFS = 2'd2;
  localparam logic [1:0] CTRL_OFS = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_NEMPTY = 0;
  localparam int STAT_FULL   = 3;
  localparam int STAT_IE     = 4;
  localparam int STAT_OVR    = 5;
  localparam int CTRL_IE     = 4;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_uart_regs.sv
// AXI4-Lite slave front-end for a UART: RX pop, TX push, STAT, CTRL, IRQ.
// Ports: S_AXI_* slave channels, RX_data/Empty/rd_uart_en (RX FIFO),
// TX_data/wr_uart_en/Full (TX FIFO), Interrupt (one-cycle pulse).
module axil_uart_regs
  import axil_uart_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_DATA_BITS        = 8
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              Interrupt,
  input  logic [C_DATA_BITS-1:0]            RX_data,
  input  logic                              Empty,
  output logic                              rd_uart_en,
  output logic [C_DATA_BITS-1:0]            TX_data,
  output logic                              wr_uart_en,
  input  logic                              Full
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic aw_rdy, ar_rdy;
  logic aw_acc, ar_acc;
  logic ie, ovr;
  logic empty_q, full_q;

  logic [1:0] waddr, raddr;
  logic       w_push, w_ovr, w_ctrl;
  logic [1:0] w_resp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_data;

  logic unused;
  assign unused = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

  assign waddr = S_AXI_AWADDR[3:2];
  assign raddr = S_AXI_ARADDR[3:2];

  assign aw_acc = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign ar_acc = ar_rdy & S_AXI_ARVALID;

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_RVALID  = (rd_state == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;

  // Write-side FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) wr_state <= W_IDLE;
    else                wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: if (aw_acc) wr_next = W_RESP;
      W_RESP: if (S_AXI_BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Write decode; Full is taken as seen in the accept cycle
  always_comb begin
    w_push = 1'b0;
    w_ovr  = 1'b0;
    w_ctrl = 1'b0;
    w_resp = RESP_OKAY;
    unique case (waddr)
      TX_OFS: begin
        if (Full) begin
          w_ovr  = 1'b1;
          w_resp = RESP_SLVERR;
        end else begin
          w_push = S_AXI_WSTRB[0];
        end
      end
      CTRL_OFS: w_ctrl = S_AXI_WSTRB[0];
      default:  w_resp = RESP_SLVERR;
    endcase
  end

  // Read-side FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rd_state <= R_IDLE;
    else                rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE: if (ar_acc) rd_next = R_DATA;
      R_DATA: if (S_AXI_RREADY) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    r_data = '0;
    unique case (raddr)
      RX_OFS: if (!Empty) r_data[C_DATA_BITS-1:0] = RX_data;
      STAT_OFS: begin
        r_data[STAT_NEMPTY] = !Empty;
        r_data[STAT_FULL]   = Full;
        r_data[STAT_IE]     = ie;
        r_data[STAT_OVR]    = ovr;
      end
      CTRL_OFS: r_data[CTRL_IE] = ie;
      default: r_data = '0;
    endcase
  end

  // Ready is registered for one cycle, and only while the response
  // channel is idle, so a held response blocks new accepts.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_rdy      <= 1'b0;
      ar_rdy      <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
      S_AXI_RDATA <= '0;
      TX_data     <= '0;
      wr_uart_en  <= 1'b0;
      rd_uart_en  <= 1'b0;
      ie          <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      aw_rdy <= !aw_rdy & (wr_state == W_IDLE)
              & S_AXI_AWVALID & S_AXI_WVALID;
      ar_rdy <= !ar_rdy & (rd_state == R_IDLE) & S_AXI_ARVALID;
      wr_uart_en <= aw_acc & w_push;
      rd_uart_en <= ar_acc & (raddr == RX_OFS) & !Empty;
      if (aw_acc) S_AXI_BRESP <= w_resp;
      if (aw_acc & w_push) TX_data <= S_AXI_WDATA[C_DATA_BITS-1:0];
      if (aw_acc & w_ctrl) ie <= S_AXI_WDATA[CTRL_IE];
      if (ar_acc) S_AXI_RDATA <= r_data;
      // Set beats the read-clear when both land together
      if (aw_acc & w_ovr)
        ovr <= 1'b1;
      else if (ar_acc & (raddr == STAT_OFS))
        ovr <= 1'b0;
    end
  end

  // Interrupt on falling Empty (data arrived) or falling Full (space freed)
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      Interrupt <= 1'b0;
    end else begin
      empty_q   <= Empty;
      full_q    <= Full;
      Interrupt <= ie & ((empty_q & !Empty) | (full_q & !Full));
    end
  end

endmodule

// File: tb/tb_axil_uart_regs.sv
// Directed testbench for axil_uart_regs.
// Drives AXI-Lite transactions and FIFO status pins, checks responses.
module tb_axil_uart_regs;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        irq;
  logic [7:0]  rx_data;
  logic        empty;
  logic        rd_en;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic        full;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int irq_cnt  = 0;
  logic [7:0] tx_last = 8'h00;
  int p0, q0, i0;

  axil_uart_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .Interrupt     (irq),
    .RX_data       (rx_data),
    .Empty         (empty),
    .rd_uart_en    (rd_en),
    .TX_data       (tx_data),
    .wr_uart_en    (wr_en),
    .Full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      push_cnt++;
      tx_last = tx_data;
    end
    if (rd_en) pop_cnt++;
    if (irq) irq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    fails++;
    $display("FAIL %s: timeout waiting for handshake", tag);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp,
                           input int hold, input string tag);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!awready) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout(tag);
    end else begin
      @(posedge clk);
      #1 awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      n = 0;
      while (!bvalid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bvalid) timeout(tag);
      else begin
        chk({tag, "_bresp"}, {30'b0, bresp}, {30'b0, exp_resp});
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk({tag, "_bhold"}, {30'b0, bresp}, {30'b0, exp_resp});
          chk({tag, "_bvalid_hold"}, {31'b0, bvalid}, 32'd1);
          chk({tag, "_no_awready"}, {31'b0, awready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
      end
    end
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp_data,
                          input int hold, input string tag);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      arvalid = 1'b0;
      timeout(tag);
    end else begin
      @(posedge clk);
      #1 arvalid = 1'b0;
      @(negedge clk);
      n = 0;
      while (!rvalid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!rvalid) timeout(tag);
      else begin
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, {30'b0, rresp}, 32'd0);
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          chk({tag, "_rhold"}, rdata, exp_data);
          chk({tag, "_no_arready"}, {31'b0, arready}, 32'd0);
        end
        rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    rx_data = '0; empty = 1'b1; full = 1'b0;
    #12;
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bresp", {30'b0, bresp}, 32'd0);
    chk("rst_txdata", {24'b0, tx_data}, 32'd0);
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset while a CTRL write response is pending
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h10; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) timeout("t1_bvalid");
    awvalid = 1'b0; wvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t1_bvalid_async", {31'b0, bvalid}, 32'd0);
    chk("t1_no_push", push_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(4'hC, 32'h0, 0, "t1_ctrl");

    // 2: normal TX push, then a write with strobe 0
    axi_write(4'h4, 32'h0000_0041, 4'hF, 2'b00, 0, "t2_tx");
    @(negedge clk);
    chk("t2_push_cnt", push_cnt, 32'd1);
    chk("t2_tx_data", {24'b0, tx_last}, 32'h41);
    axi_write(4'h4, 32'h0000_0099, 4'h0, 2'b00, 0, "t2_nostrb");
    @(negedge clk);
    chk("t2_nostrb_push", push_cnt, 32'd1);

    // 3: overrun, sticky STAT bit cleared by read, bad-address writes
    full = 1'b1;
    axi_write(4'h4, 32'h0000_0042, 4'hF, 2'b10, 0, "t3_full");
    @(negedge clk);
    chk("t3_no_push", push_cnt, 32'd1);
    axi_read(4'h8, 32'h28, 0, "t3_stat1");
    full = 1'b0;
    axi_read(4'h8, 32'h00, 0, "t3_stat2");
    axi_write(4'h0, 32'h0, 4'hF, 2'b10, 0, "t3_wr_rx");
    axi_write(4'h8, 32'h0, 4'hF, 2'b10, 0, "t3_wr_stat");
    axi_read(4'h4, 32'h0, 0, "t3_rd_tx");

    // 4: RX pop with data, then read while empty
    rx_data = 8'h5A;
    empty = 1'b0;
    axi_read(4'h0, 32'h5A, 0, "t4_rx");
    @(negedge clk);
    chk("t4_pop", pop_cnt, 32'd1);
    empty = 1'b1;
    axi_read(4'h0, 32'h0, 0, "t4_empty");
    @(negedge clk);
    chk("t4_no_pop", pop_cnt, 32'd1);
    chk("t4_no_irq", irq_cnt, 32'd0);

    // 5: interrupt enable and edge-triggered pulses
    axi_write(4'hC, 32'h0000_0010, 4'h1, 2'b00, 0, "t5_ctrl_on");
    axi_read(4'hC, 32'h10, 0, "t5_ctrl_rd");
    axi_read(4'h8, 32'h10, 0, "t5_stat");
    i0 = irq_cnt;
    @(negedge clk);
    empty = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_irq_empty", irq_cnt - i0, 32'd1);
    empty = 1'b1;
    repeat (2) @(negedge clk);
    full = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_irq_full_rise", irq_cnt - i0, 32'd1);
    full = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_irq_full_fall", irq_cnt - i0, 32'd2);
    axi_write(4'hC, 32'h0, 4'hE, 2'b00, 0, "t5_ctrl_nostrb");
    axi_read(4'hC, 32'h10, 0, "t5_ctrl_kept");
    axi_write(4'hC, 32'hFFFF_FFEF, 4'hF, 2'b00, 0, "t5_ctrl_off");
    axi_read(4'hC, 32'h0, 0, "t5_ctrl_off_rd");
    i0 = irq_cnt;
    @(negedge clk);
    empty = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_irq_disabled", irq_cnt - i0, 32'd0);
    empty = 1'b1;
    @(negedge clk);

    // 6: stalled response channels
    p0 = pop_cnt;
    q0 = push_cnt;
    rx_data = 8'h33;
    empty = 1'b0;
    axi_read(4'h0, 32'h33, 5, "t6_rx_hold");
    @(negedge clk);
    chk("t6_single_pop", pop_cnt - p0, 32'd1);
    empty = 1'b1;
    axi_write(4'h4, 32'h0000_007E, 4'h1, 2'b00, 5, "t6_tx_hold");
    @(negedge clk);
    chk("t6_single_push", push_cnt - q0, 32'd1);
    chk("t6_tx_data", {24'b0, tx_last}, 32'h7E);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
